part2_mac_pipe: RTL
===================

// Module: part2_mac_pipe
//
// PURPOSE
//  Parametrised, pipelined signed multiply-accumulate unit: f += a*b for each valid sample.
//  Next generation of the project MAC: adds an optional multiplier pipeline register and
//  an explicit accumulator-clear tag that travels with each sample.
//  Provides optional saturating accumulation with a sticky overflow flag.
//  Sits between the sample source and the result consumer in the proj2 datapath.
//  It has no back-pressure: the consumer must accept one result per cycle.
//
// PARAMETERS
//  WIDTH      10  signed input operand width (a, b)
//  OUT_WIDTH  20  signed accumulator/output width; must be >= 2*WIDTH
//  MUL_PIPE   1   0: product feeds the accumulator directly; 1: product is registered
//
// PORTS
//  clk        in   1          clock; all state updates on posedge
//  reset      in   1          synchronous, active-low (0 = reset asserted)
//  a          in   WIDTH      signed operand A
//  b          in   WIDTH      signed operand B
//  clear_in   in   1          sample starts a new accumulation (qualified by valid_in)
//  valid_in   in   1          a/b/clear_in are valid this cycle
//  f          out  OUT_WIDTH  signed accumulated result
//  valid_out  out  1          f was updated by a sample in the previous cycle
//  overflow   out  1          sticky overflow flag (see CONFIGURATION)
//
// BEHAVIOUR
//  - Reset (reset==0 at posedge): f=0, valid_out=0, overflow=0.
//    All pipeline registers and valid/clear tags are cleared, so in-flight samples are
//    discarded. Reset overrides every other input.
//  - Stage 1: on valid_in=1, register a, b, clear_in and set v1=1; otherwise v1=0.
//    Data registers hold their value when v1=0.
//  - Stage 2 (MUL_PIPE=1 only): p = a_r*b_r (signed, 2*WIDTH bits) is registered together
//    with v2 and the clear tag. With MUL_PIPE=0 this stage is a wire.
//  - Accumulate stage, when the valid tag is 1:
//      f <= clear ? sext(p) : f + sext(p), and valid_out <= 1.
//    When the valid tag is 0: f holds and valid_out <= 0.
//  - Latency from valid_in to valid_out is 2+MUL_PIPE cycles. Throughput is one sample per
//    cycle. Bubbles propagate unchanged; no ordering change or merging.
//  - The product is sign-extended to OUT_WIDTH before the add; the add is OUT_WIDTH wide.
//  - Overflow: detected when both addend signs are equal and the sum sign differs.
//    A cleared sample never overflows.
//  - A clear tag on a sample resets the accumulation base to that sample's product.
//    It also clears overflow in the same cycle; an overflow on that cycle is impossible.
//  - The first sample after reset accumulates onto f=0, whether or not clear_in is set.
//
// CONFIGURATION
//  Macro: MAC_SATURATE_EN
//  - Defined: on overflow, f clamps to +(2^(OUT_WIDTH-1)-1) when the addends are positive,
//    and to -(2^(OUT_WIDTH-1)) when they are negative. overflow is set to 1 and stays set
//    (sticky) until reset or the next cleared sample.
//  - Undefined: f wraps modulo 2^OUT_WIDTH, overflow is tied to 0, and no detection logic
//    is synthesised.
//
// TESTING (WIDTH=10, OUT_WIDTH=20, MUL_PIPE=1 unless stated)
//  1. Hold reset=0 for 2 cycles with valid_in=1, then release
//     -> f=0, valid_out=0, overflow=0 throughout, and no valid_out for 3 cycles after release.
//  2. Back-to-back samples (3,4,clr=1), (-5,6), (7,-2) at cycles 0,1,2
//     -> valid_out=1 at cycles 3,4,5 with f=12, -18, -32.
//  3. Samples (2,3,clr=1), gap, (1,1) at cycles 0,2
//     -> valid_out 1,0,1 at cycles 3,4,5; f=6 holds at cycle 4, then f=7.
//  4. After f=7, send (2,2,clr=1) -> f=4 (not 11) after 3 cycles.
//     Repeat with MUL_PIPE=0 -> same values after 2 cycles.
//  5. (-512,-512,clr=1) then (-512,-512)
//     -> f=262144, then 524288 overflows:
//       * with MAC_SATURATE_EN: f=524287, overflow=1, and it stays 1 until a cleared sample.
//       * without the macro: f=-524288, overflow=0.
//  6. Send 2 samples, then assert reset for 1 cycle while they are in flight
//     -> neither sample produces valid_out, and f=0 after reset.

Source files
------------

// File: rtl/part2_mac_pipe_if.sv
// ---------------------------------------------------------------------------
// part2_mac_pipe_if
//   Sample/result bundle for the part2_mac_pipe multiply-accumulate unit.
//   Parameters must match those of the MAC instance the bundle is attached to.
//
//   Signals
//     a, b       signed operands (WIDTH)
//     clear_in   sample starts a new accumulation
//     valid_in   a/b/clear_in are valid this cycle
//     f          signed accumulated result (OUT_WIDTH)
//     valid_out  f was updated by a sample in the previous cycle
//     overflow   sticky overflow flag (0 unless MAC_SATURATE_EN is defined)
//
//   Modports
//     master     sample source / result consumer side
//     slave      MAC side
// ---------------------------------------------------------------------------
interface part2_mac_pipe_if #(
    parameter int WIDTH     = 10,
    parameter int OUT_WIDTH = 20
) ();
    logic signed [WIDTH-1:0]     a;
    logic signed [WIDTH-1:0]     b;
    logic                        clear_in;
    logic                        valid_in;
    logic signed [OUT_WIDTH-1:0] f;
    logic                        valid_out;
    logic                        overflow;

    modport master (
        output a, b, clear_in, valid_in,
        input  f, valid_out, overflow
    );

    modport slave (
        input  a, b, clear_in, valid_in,
        output f, valid_out, overflow
    );
endinterface

// File: rtl/part2_mac_pipe.sv
// ---------------------------------------------------------------------------
// part2_mac_pipe
//   Pipelined signed multiply-accumulate: f += a*b for every valid sample.
//   A clear tag travelling with a sample restarts the accumulation from that
//   sample's product. No back-pressure: one result per cycle at most.
//
//   Latency valid_in -> valid_out is 2+MUL_PIPE cycles, one sample per cycle.
//
//   Parameters
//     WIDTH      signed operand width
//     OUT_WIDTH  signed accumulator width, must be >= 2*WIDTH
//     MUL_PIPE   1: register the product before accumulation, 0: feed it directly
//
//   Ports
//     clk        clock, all state updates on posedge
//     reset      synchronous, active-low; clears every stage (in-flight samples lost)
//     bus        part2_mac_pipe_if.slave: a, b, clear_in, valid_in in;
//                f, valid_out, overflow out
//
//   Build option
//     MAC_SATURATE_EN  defined: saturating accumulate with sticky overflow flag
//                      undefined: wrap-around accumulate, overflow tied to 0
// ---------------------------------------------------------------------------
module part2_mac_pipe #(
    parameter int WIDTH     = 10,
    parameter int OUT_WIDTH = 20,
    parameter int MUL_PIPE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    part2_mac_pipe_if.slave  bus
);

    localparam int PW = 2 * WIDTH;

`ifdef MAC_SATURATE_EN
    localparam logic signed [OUT_WIDTH-1:0] F_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] F_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // Two's-complement overflow: equal addend signs, different sum sign.
    function automatic logic add_ovf(
        input logic signed [OUT_WIDTH-1:0] x,
        input logic signed [OUT_WIDTH-1:0] y,
        input logic signed [OUT_WIDTH-1:0] s
    );
        return (x[OUT_WIDTH-1] == y[OUT_WIDTH-1]) && (s[OUT_WIDTH-1] != x[OUT_WIDTH-1]);
    endfunction

    // Clamp towards the sign shared by both addends when the add overflowed.
    function automatic logic signed [OUT_WIDTH-1:0] sat_sum(
        input logic signed [OUT_WIDTH-1:0] x,
        input logic signed [OUT_WIDTH-1:0] s,
        input logic                        ovf
    );
        if (!ovf)
            return s;
        return x[OUT_WIDTH-1] ? F_MIN : F_MAX;
    endfunction
`endif

    // ---- stage 1: operand capture ----
    logic signed [WIDTH-1:0] a_p1_d, a_p1_q;
    logic signed [WIDTH-1:0] b_p1_d, b_p1_q;
    logic                    clr_p1_d, clr_p1_q;
    logic                    vld_p1_d, vld_p1_q;

    always_comb begin
        vld_p1_d = bus.valid_in;
        a_p1_d   = a_p1_q;
        b_p1_d   = b_p1_q;
        clr_p1_d = clr_p1_q;
        if (bus.valid_in) begin
            a_p1_d   = bus.a;
            b_p1_d   = bus.b;
            clr_p1_d = bus.clear_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_p1_q   <= '0;
            b_p1_q   <= '0;
            clr_p1_q <= 1'b0;
            vld_p1_q <= 1'b0;
        end else begin
            a_p1_q   <= a_p1_d;
            b_p1_q   <= b_p1_d;
            clr_p1_q <= clr_p1_d;
            vld_p1_q <= vld_p1_d;
        end
    end

    // Operands widened first so the product is full precision.
    logic signed [PW-1:0] prod_p1;
    assign prod_p1 = PW'(a_p1_q) * PW'(b_p1_q);

    // ---- stage 2: optional product register ----
    logic signed [PW-1:0] prod_acc;
    logic                 clr_acc;
    logic                 vld_acc;

    if (MUL_PIPE != 0) begin : g_mul_reg
        logic signed [PW-1:0] prod_p2_d, prod_p2_q;
        logic                 clr_p2_d, clr_p2_q;
        logic                 vld_p2_d, vld_p2_q;

        always_comb begin
            vld_p2_d  = vld_p1_q;
            prod_p2_d = prod_p2_q;
            clr_p2_d  = clr_p2_q;
            if (vld_p1_q) begin
                prod_p2_d = prod_p1;
                clr_p2_d  = clr_p1_q;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                prod_p2_q <= '0;
                clr_p2_q  <= 1'b0;
                vld_p2_q  <= 1'b0;
            end else begin
                prod_p2_q <= prod_p2_d;
                clr_p2_q  <= clr_p2_d;
                vld_p2_q  <= vld_p2_d;
            end
        end

        assign prod_acc = prod_p2_q;
        assign clr_acc  = clr_p2_q;
        assign vld_acc  = vld_p2_q;
    end else begin : g_mul_wire
        assign prod_acc = prod_p1;
        assign clr_acc  = clr_p1_q;
        assign vld_acc  = vld_p1_q;
    end

    // ---- accumulate stage ----
    logic signed [OUT_WIDTH-1:0] addend;
    logic signed [OUT_WIDTH-1:0] sum;
    logic signed [OUT_WIDTH-1:0] f_d, f_q;
    logic                        valid_out_d, valid_out_q;

    assign addend = OUT_WIDTH'(prod_acc);
    assign sum    = f_q + addend;

`ifdef MAC_SATURATE_EN
    logic ovf_now;
    logic overflow_d, overflow_q;

    // A cleared sample starts from the product alone, so it cannot overflow.
    assign ovf_now = !clr_acc && add_ovf(f_q, addend, sum);

    always_comb begin
        f_d         = f_q;
        overflow_d  = overflow_q;
        valid_out_d = vld_acc;
        if (vld_acc) begin
            if (clr_acc) begin
                f_d        = addend;
                overflow_d = 1'b0;
            end else begin
                f_d        = sat_sum(f_q, sum, ovf_now);
                overflow_d = overflow_q | ovf_now;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            f_q         <= '0;
            overflow_q  <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            f_q         <= f_d;
            overflow_q  <= overflow_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.overflow = overflow_q;
`else
    always_comb begin
        f_d         = f_q;
        valid_out_d = vld_acc;
        if (vld_acc)
            f_d = clr_acc ? addend : sum;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            f_q         <= '0;
            valid_out_q <= 1'b0;
        end else begin
            f_q         <= f_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.overflow = 1'b0;
`endif

    assign bus.f         = f_q;
    assign bus.valid_out = valid_out_q;

endmodule
